// File: rtl/vc_dest_arbiter_pkg.sv
// Shared definitions for the two-VC weighted round-robin destination arbiter.
package vc_dest_arbiter_pkg;

  localparam int WGT_W_DEF = 4;
  localparam int CNT_W_DEF = 8;

  localparam logic VC0 = 1'b0;
  localparam logic VC1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SERVE0 = 2'b01,
    SERVE1 = 2'b10
  } state_t;

endpackage

// File: rtl/vc_credit_counter.sv
// Per-VC turn credit: loads the weight (0 read as 1) at turn start and counts pops down.
module vc_credit_counter
  import vc_dest_arbiter_pkg::*;
#(
  parameter int WGT_W = WGT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             load,
  input  logic             dec,
  input  logic [WGT_W-1:0] weight,
  output logic             last
);

  logic [WGT_W-1:0] credit;

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      credit <= '0;
    end else if (load) begin
      credit <= (weight == '0) ? WGT_W'(1) : weight;
    end else if (dec) begin
      credit <= credit - WGT_W'(1);
    end
  end

  // Final pop of the turn; zero only occurs outside a turn.
  assign last = (credit <= WGT_W'(1));

endmodule

// File: rtl/vc_dest_arbiter.sv
// Weighted round-robin drain of VC0/VC1 toward the destination demux, honouring per-destination pause.
module vc_dest_arbiter
  import vc_dest_arbiter_pkg::*;
#(
  parameter int WGT_W = WGT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             vc0_empty,
  input  logic             vc1_empty,
  input  logic             vc0_dest,
  input  logic             vc1_dest,
  input  logic             pause_d0,
  input  logic             pause_d1,
  input  logic [WGT_W-1:0] weight_vc0,
  input  logic [WGT_W-1:0] weight_vc1,
  output logic             pop_vc0,
  output logic             pop_vc1,
  output logic             valid_vc0,
  output logic             valid_vc1,
  output logic             busy,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  state_t state;
  logic   last_served;
  logic   elig0, elig1;
  logic   last0, last1;
  logic   end0, end1, go0, go1;
  logic   load0, load1, dec0, dec1;

  assign elig0 = !vc0_empty && !(vc0_dest ? pause_d1 : pause_d0);
  assign elig1 = !vc1_empty && !(vc1_dest ? pause_d1 : pause_d0);

  assign pop_vc0 = (state == SERVE0) && elig0;
  assign pop_vc1 = (state == SERVE1) && elig1;
  assign busy    = (state != IDLE);

  // Turn bookkeeping shared by the FSM and the credit counters.
  always_comb begin
    end0  = (state == SERVE0) && !(pop_vc0 && !last0);
    end1  = (state == SERVE1) && !(pop_vc1 && !last1);
    go0   = ((state == IDLE) && elig0 && (!elig1 || last_served == VC1)) || (end1 && elig0);
    go1   = ((state == IDLE) && elig1 && (!elig0 || last_served == VC0)) || (end0 && elig1);
    load0 = go0 || (end0 && !elig1 && elig0);
    load1 = go1 || (end1 && !elig0 && elig1);
    dec0  = pop_vc0 && !last0;
    dec1  = pop_vc1 && !last1;
  end

  vc_credit_counter #(.WGT_W(WGT_W)) u_credit0 (
    .clk     (clk),
    .reset_L (reset_L),
    .load    (load0),
    .dec     (dec0),
    .weight  (weight_vc0),
    .last    (last0)
  );

  vc_credit_counter #(.WGT_W(WGT_W)) u_credit1 (
    .clk     (clk),
    .reset_L (reset_L),
    .load    (load1),
    .dec     (dec1),
    .weight  (weight_vc1),
    .last    (last1)
  );

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state       <= IDLE;
      last_served <= VC1;
      valid_vc0   <= 1'b0;
      valid_vc1   <= 1'b0;
      grant_cnt0  <= '0;
      grant_cnt1  <= '0;
    end else begin
      valid_vc0  <= pop_vc0;
      valid_vc1  <= pop_vc1;
      grant_cnt0 <= grant_cnt0 + CNT_W'(pop_vc0);
      grant_cnt1 <= grant_cnt1 + CNT_W'(pop_vc1);
      unique case (state)
        IDLE: begin
          if (go0) begin
            state       <= SERVE0;
            last_served <= VC0;
          end else if (go1) begin
            state       <= SERVE1;
            last_served <= VC1;
          end
        end
        SERVE0: begin
          if (end0) begin
            if (go1) begin
              state       <= SERVE1;
              last_served <= VC1;
            end else if (!elig0) begin
              state <= IDLE;
            end
          end
        end
        SERVE1: begin
          if (end1) begin
            if (go0) begin
              state       <= SERVE0;
              last_served <= VC0;
            end else if (!elig1) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
